// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: fetch-PC source select,
// sequencer states and default vector addresses.
package pipe_pkg;

    typedef enum logic [2:0] {
        PCS_SEQ    = 3'd0,
        PCS_BRANCH = 3'd1,
        PCS_JUMP   = 3'd2,
        PCS_JREG   = 3'd3,
        PCS_ILLOP  = 3'd4,
        PCS_XADR   = 3'd5,
        PCS_HOLD   = 3'd6
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_KERNEL = 2'd2
    } hz_state_e;

    localparam logic [31:0] ILLOP_DEFAULT = 32'h8000_0004;
    localparam logic [31:0] XADR_DEFAULT  = 32'h8000_0008;
    localparam int          CNT_W_DEFAULT = 16;

endpackage

// File: rtl/loaduse_detect.sv
// Load-use hazard detect: the load in EX writes a register the ID instruction reads.
module loaduse_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu
);

    // $zero is never a real dependency, so a load into r0 never stalls.
    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline front-end sequencer: picks the fetch-PC source, drives IF/ID and ID/EX
// stall/flush, and runs interrupt/exception entry and kernel exit.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] ILLOP = ILLOP_DEFAULT,
    parameter logic [31:0] XADR  = XADR_DEFAULT,
    parameter int          CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic             id_exp,
    input  logic             id_jump_i,
    input  logic             id_jump_r,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_en,
    output logic [2:0]       pc_sel,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [31:0]      epc,
    output logic             in_kernel,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_e state;
    pc_sel_e   sel;
    logic      lu;
    logic      safe;
    logic      user_code;
    logic      take_irq;
    logic      take_exc;
    logic      stall;

    loaduse_detect u_loaduse_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .lu          (lu)
    );

    // A user-mode instruction in ID with nothing about to redirect or stall it is
    // the only point where an interrupt can replay it cleanly from EPC.
    assign user_code = id_valid && !id_pc[31];
    assign safe      = user_code && !ex_branch_en && !id_jump_i && !id_jump_r && !lu;

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
        sel        = PCS_SEQ;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        take_irq   = 1'b0;
        take_exc   = 1'b0;
        stall      = 1'b0;
        if (!reset) begin
            if (state == ST_PEND && safe && !id_exp) begin
                take_irq   = 1'b1;
                sel        = PCS_ILLOP;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (id_exp && id_valid) begin
                take_exc   = 1'b1;
                sel        = PCS_XADR;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (ex_branch_en) begin
                sel        = PCS_BRANCH;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (id_jump_i) begin
                sel        = PCS_JUMP;
                ifid_flush = 1'b1;
            end else if (id_jump_r) begin
                sel        = PCS_JREG;
                ifid_flush = 1'b1;
            end else if (lu) begin
                stall      = 1'b1;
                sel        = PCS_HOLD;
                ifid_hold  = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset, and non-blocking assignments so every read in this block sees pre-edge values.
        if (reset) begin
            state     <= ST_RUN;
            epc       <= 32'd0;
            stall_cnt <= '0;
        end else begin
            if (take_irq) begin
                epc   <= id_pc;
                state <= ST_KERNEL;
            end else if (take_exc) begin
                // Skip the faulting instruction on return; an outstanding IRQ is
                // dropped here and re-sampled from the level after kernel exit.
                epc   <= id_pc + 32'd4;
                state <= ST_KERNEL;
            end else begin
                unique case (state)
                    ST_RUN:    if (irq && !id_pc[31]) state <= ST_PEND;
                    ST_PEND:   if (!irq)              state <= ST_RUN;
                    ST_KERNEL: if (user_code)         state <= ST_RUN;
                    default:                          state <= ST_RUN;
                endcase
            end
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign pc_sel    = sel;
    assign in_kernel = (state == ST_KERNEL);

    vec_aligned_a: assert property (@(posedge clk) (ILLOP[1:0] == 2'b00) && (XADR[1:0] == 2'b00));
    hold_flush_excl_a: assert property (@(posedge clk) disable iff (reset) !(ifid_hold && ifid_flush));

endmodule
